// File: rtl/p2p_pkt_fifo.sv
// p2p_pkt_fifo
// Store-and-forward AXI-stream packet FIFO on a single clock (cmac_clk).
// A packet becomes visible on m_axis only after its tlast beat is accepted.
// Packets can be discarded on ingress, either because their tlast beat
// carries tuser_err while cfg_drop_err=1, or because one packet alone
// would need more than DEPTH entries.
// Optional feature: define P2P_PKT_FIFO_STATS_EN to add the pkt_cnt and
// drop_cnt statistics outputs. Without it the block has no counters.
module p2p_pkt_fifo #(
   parameter int TDATA_W = 512,
   parameter int DEPTH   = 64
) (
   input  logic                      cmac_clk,
   input  logic                      cmac_rst,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic [TDATA_W-1:0]        s_axis_tdata,
   input  logic [TDATA_W/8-1:0]      s_axis_tkeep,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tuser_err,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [TDATA_W-1:0]        m_axis_tdata,
   output logic [TDATA_W/8-1:0]      m_axis_tkeep,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tuser_err,
   input  logic                      cfg_drop_err,
   output logic [$clog2(DEPTH):0]    fill_level,
   output logic                      drop_pulse
`ifdef P2P_PKT_FIFO_STATS_EN
   ,
   output logic [31:0]               pkt_cnt,
   output logic [31:0]               drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int KW = TDATA_W / 8;
   localparam int EW = TDATA_W + KW + 2;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   typedef enum logic {
      ST_ACCEPT = 1'b0,
      ST_DROP   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_q, wr_d;
   logic [PW-1:0]   cmt_q, cmt_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic            drop_pulse_q, drop_pulse_d;
   logic [PW-1:0]   occ;
   logic [PW-1:0]   occ_d;
   logic            s_fire;
   logic            m_fire;
   logic            wr_en;
   logic            commit;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   rd_word;

`ifdef P2P_PKT_FIFO_STATS_EN
   logic [31:0]     pkt_cnt_q, pkt_cnt_d;
   logic [31:0]     drop_cnt_q, drop_cnt_d;
`endif

   // Handshake qualifiers, all derived from registered pointers/state.
   always_comb begin
      occ           = wr_q - rd_q;
      s_axis_tready = !cmac_rst && ((state_q == ST_DROP) || !occ[AW]);
      m_axis_tvalid = !cmac_rst && (rd_q != cmt_q);
      s_fire        = s_axis_tvalid && s_axis_tready;
      m_fire        = m_axis_tvalid && m_axis_tready;
      wr_en         = s_fire && (state_q == ST_ACCEPT);
   end

   // Next-state logic for pointers, ingress state and drop signalling.
   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      cmt_d        = cmt_q;
      rd_d         = rd_q;
      drop_pulse_d = 1'b0;
      commit       = 1'b0;
      if (m_fire) begin
         rd_d = rd_q + 1'b1;
      end
      if (s_fire) begin
         if (state_q == ST_DROP) begin
            if (s_axis_tlast) begin
               state_d = ST_ACCEPT;
            end
         end else begin
            wr_d = wr_q + 1'b1;
            if (s_axis_tlast) begin
               if (s_axis_tuser_err && cfg_drop_err) begin
                  wr_d         = cmt_q;
                  drop_pulse_d = 1'b1;
               end else begin
                  cmt_d  = wr_q + 1'b1;
                  commit = 1'b1;
               end
            end
         end
      end
      // A lone uncommitted packet occupying every entry can never be
      // forwarded. Catching it on the beat that fills the FIFO (rather than
      // a cycle later) means ingress never sees backpressure for it.
      occ_d = wr_d - rd_d;
      if ((state_q == ST_ACCEPT) && (occ_d == DEPTH_P) && (cmt_d == rd_d)) begin
         wr_d         = cmt_d;
         state_d      = ST_DROP;
         drop_pulse_d = 1'b1;
      end
   end

`ifdef P2P_PKT_FIFO_STATS_EN
   // Saturating statistics counters.
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (commit && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
         pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
      if (drop_pulse_d && (drop_cnt_q != 32'hFFFF_FFFF)) begin
         drop_cnt_d = drop_cnt_q + 32'd1;
      end
   end
`endif

   // Control state registers; reset discards all stored and partial data.
   always_ff @(posedge cmac_clk) begin
      if (cmac_rst) begin
         state_q      <= ST_ACCEPT;
         wr_q         <= '0;
         cmt_q        <= '0;
         rd_q         <= '0;
         drop_pulse_q <= 1'b0;
`ifdef P2P_PKT_FIFO_STATS_EN
         pkt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         cmt_q        <= cmt_d;
         rd_q         <= rd_d;
         drop_pulse_q <= drop_pulse_d;
`ifdef P2P_PKT_FIFO_STATS_EN
         pkt_cnt_q    <= pkt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
`endif
      end
   end

   // Beat storage. Read is asynchronous so the head entry is on m_axis the
   // cycle after commit and holds steady while the consumer stalls.
   always_ff @(posedge cmac_clk) begin
      if (wr_en) begin
         mem[wr_q[AW-1:0]] <= {s_axis_tuser_err, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      end
   end

   assign rd_word          = mem[rd_q[AW-1:0]];
   assign m_axis_tdata     = rd_word[TDATA_W-1:0];
   assign m_axis_tkeep     = rd_word[TDATA_W+KW-1:TDATA_W];
   assign m_axis_tlast     = rd_word[TDATA_W+KW];
   assign m_axis_tuser_err = rd_word[TDATA_W+KW+1];
   assign fill_level       = occ;
   assign drop_pulse       = drop_pulse_q;

`ifdef P2P_PKT_FIFO_STATS_EN
   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_p2p_pkt_fifo.sv
// tb_p2p_pkt_fifo
// Randomized and directed stimulus for p2p_pkt_fifo, checked every cycle
// against a packet-level reference model built from queues.
// Define P2P_PKT_FIFO_STATS_EN to also check the statistics counters.
module tb_p2p_pkt_fifo;

   localparam int DW    = 64;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 16;
   localparam int PW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic          err;
      logic          last;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          cmac_rst;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tlast;
   logic          s_axis_tuser_err;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic          m_axis_tuser_err;
   logic          cfg_drop_err;
   logic [PW-1:0] fill_level;
   logic          drop_pulse;
`ifdef P2P_PKT_FIFO_STATS_EN
   logic [31:0]   pkt_cnt;
   logic [31:0]   drop_cnt;
`endif

   always #5 clk = ~clk;

   p2p_pkt_fifo #(
      .TDATA_W (DW),
      .DEPTH   (DEPTH)
   ) dut (
      .cmac_clk         (clk),
      .cmac_rst         (cmac_rst),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tkeep     (s_axis_tkeep),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tuser_err (s_axis_tuser_err),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tkeep     (m_axis_tkeep),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tuser_err (m_axis_tuser_err),
      .cfg_drop_err     (cfg_drop_err),
      .fill_level       (fill_level),
      .drop_pulse       (drop_pulse)
`ifdef P2P_PKT_FIFO_STATS_EN
      ,
      .pkt_cnt          (pkt_cnt),
      .drop_cnt         (drop_cnt)
`endif
   );

   // Scoreboard counters
   int n_checks = 0;
   int n_errors = 0;

   // Reference model: committed beats awaiting egress, and the packet being received
   beat_t exp_q[$];
   beat_t part_q[$];
   bit    in_drop   = 1'b0;
   bit    exp_pulse = 1'b0;
   bit    rst_lvl   = 1'b1;
   int    pkt_model = 0;
   int    drop_model = 0;

   // Stimulus controls
   beat_t drv_q[$];
   beat_t cur;
   bit    cur_valid = 1'b0;
   bit    rst_req   = 1'b1;
   int    vprob     = 100;
   int    rdy_prob  = 100;
   int    cfg_mode  = 0;
   int    acc_cnt   = 0;
   int    out_pkts  = 0;
   int    out_beats = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int occ_m();
      return exp_q.size() + part_q.size();
   endfunction

   // One clock cycle: check outputs, drive inputs, advance the model.
   task automatic step();
      bit exp_rdy;
      bit exp_vld;
      bit s_hs;
      bit m_hs;
      bit pulse;
      @(negedge clk);
      exp_rdy = !rst_lvl && (in_drop || (occ_m() < DEPTH));
      exp_vld = !rst_lvl && (exp_q.size() > 0);
      chk("s_tready", s_axis_tready, exp_rdy);
      chk("m_tvalid", m_axis_tvalid, exp_vld);
      chk("fill_level", fill_level, occ_m());
      chk("drop_pulse", drop_pulse, exp_pulse);
      if (exp_vld) begin
         chk("m_tdata", m_axis_tdata, exp_q[0].data);
         chk("m_tkeep", m_axis_tkeep, exp_q[0].keep);
         chk("m_tlast", m_axis_tlast, exp_q[0].last);
         chk("m_terr", m_axis_tuser_err, exp_q[0].err);
      end
`ifdef P2P_PKT_FIFO_STATS_EN
      chk("pkt_cnt", pkt_cnt, pkt_model);
      chk("drop_cnt", drop_cnt, drop_model);
`endif

      if (!cur_valid && (drv_q.size() > 0) && ($urandom_range(0, 99) < vprob)) begin
         cur       = drv_q.pop_front();
         cur_valid = 1'b1;
      end
      s_axis_tvalid    = cur_valid;
      s_axis_tdata     = cur.data;
      s_axis_tkeep     = cur.keep;
      s_axis_tlast     = cur.last;
      s_axis_tuser_err = cur.err;
      m_axis_tready    = ($urandom_range(0, 99) < rdy_prob);
      case (cfg_mode)
         0:       cfg_drop_err = 1'b0;
         1:       cfg_drop_err = 1'b1;
         default: cfg_drop_err = $urandom_range(0, 1) == 1;
      endcase
      cmac_rst = rst_req;
      rst_lvl  = rst_req;

      if (rst_req) begin
         exp_q.delete();
         part_q.delete();
         in_drop    = 1'b0;
         exp_pulse  = 1'b0;
         cur_valid  = 1'b0;
         pkt_model  = 0;
         drop_model = 0;
      end else begin
         exp_rdy = in_drop || (occ_m() < DEPTH);
         exp_vld = exp_q.size() > 0;
         s_hs    = cur_valid && exp_rdy;
         m_hs    = exp_vld && m_axis_tready;
         pulse   = 1'b0;
         if (m_hs) begin
            out_beats++;
            if (exp_q[0].last) begin
               out_pkts++;
               $display("egress pkt %0d: %0d beats, err=%0b", out_pkts, out_beats, exp_q[0].err);
               out_beats = 0;
            end
            void'(exp_q.pop_front());
         end
         if (s_hs) begin
            acc_cnt++;
            cur_valid = 1'b0;
            if (in_drop) begin
               if (cur.last) in_drop = 1'b0;
            end else begin
               part_q.push_back(cur);
               if (cur.last) begin
                  if (cur.err && cfg_drop_err) begin
                     pulse = 1'b1;
                     drop_model++;
                  end else begin
                     foreach (part_q[i]) exp_q.push_back(part_q[i]);
                     pkt_model++;
                  end
                  part_q.delete();
               end else if (part_q.size() == DEPTH) begin
                  // packet cannot fit even with an empty FIFO
                  part_q.delete();
                  in_drop = 1'b1;
                  pulse   = 1'b1;
                  drop_model++;
               end
            end
         end
         exp_pulse = pulse;
      end
   endtask

   task automatic push_pkt(input int len, input bit err);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom, $urandom};
         b.last = (i == len - 1);
         b.keep = b.last ? KW'($urandom_range(1, (1 << KW) - 1)) : '1;
         b.err  = b.last ? err : 1'b0;
         drv_q.push_back(b);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (((drv_q.size() > 0) || cur_valid || (exp_q.size() > 0)) && (n < budget)) begin
         step();
         n++;
      end
      step();
      step();
      chk("drain_done", (n < budget), 1'b1);
   endtask

   initial begin
      int start;
      int n;
      cmac_rst = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      s_axis_tlast = 1'b0;
      s_axis_tuser_err = 1'b0;
      m_axis_tready = 1'b0;
      cfg_drop_err = 1'b0;
      cur = '0;
      @(posedge clk);
      repeat (3) step();
      rst_req = 1'b0;
      step();

      $display("test: 3-beat packet, egress ready");
      push_pkt(3, 1'b0);
      drain(200);

      $display("test: errored 4-beat packet, drop enabled");
      cfg_mode = 1;
      push_pkt(4, 1'b1);
      drain(200);

      $display("test: errored 4-beat packet, drop disabled");
      cfg_mode = 0;
      push_pkt(4, 1'b1);
      drain(200);

      $display("test: exact-depth packet, oversize packet, then 2-beat packet");
      push_pkt(DEPTH, 1'b0);
      drain(200);
      push_pkt(DEPTH + 4, 1'b0);
      push_pkt(2, 1'b0);
      drain(200);

      $display("test: egress stalled while one-beat packets fill the FIFO");
      rdy_prob = 0;
      for (int i = 0; i < DEPTH + 1; i++) push_pkt(1, 1'b0);
      repeat (DEPTH + 8) step();
      rdy_prob = 100;
      drain(400);

      $display("test: reset in the middle of a 5-beat packet");
      rdy_prob = 100;
      push_pkt(5, 1'b0);
      start = acc_cnt;
      n = 0;
      while ((acc_cnt < start + 2) && (n < 100)) begin
         step();
         n++;
      end
      chk("mid_pkt_beats", acc_cnt - start, 2);
      rst_req = 1'b1;
      repeat (2) step();
      drv_q.delete();
      rst_req = 1'b0;
      step();
      push_pkt(1, 1'b0);
      drain(200);

      $display("test: randomized traffic");
      for (int b = 0; b < 30; b++) begin
         cfg_mode = $urandom_range(0, 2);
         rdy_prob = $urandom_range(10, 100);
         vprob    = $urandom_range(50, 100);
         for (int p = 0; p < 10; p++) begin
            if ($urandom_range(0, 19) == 0) push_pkt($urandom_range(DEPTH - 1, DEPTH + 4), $urandom_range(0, 3) == 0);
            else push_pkt($urandom_range(1, 8), $urandom_range(0, 3) == 0);
         end
         drain(3000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
